// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control FSM for a multi-cycle RV32I datapath. It fetches an instruction
//   over a shared memory handshake, decodes it, steers the datapath selects
//   for one execute cycle and, where needed, performs a data-memory access
//   and a register write-back. Memory waits are bounded by a timeout counter.
//   Illegal opcodes either trap or are skipped, depending on TRAP_ON_ILLEGAL.
//
// Parameters
//   TO_W             width of the memory-wait timeout counter
//   TRAP_ON_ILLEGAL  1: illegal opcode enters TRAP, 0: treated as a NOP
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   instr[31:0]              instruction word (valid from DECODE onward)
//   mem_ack                  memory transfer complete (single-cycle pulse)
//   br_eq, br_lt, br_ltu     rs1 vs rs2 comparator results
//   mem_req, mem_we          memory request / store qualifier
//   ir_we, pc_we             instruction-register / PC write strobes
//   PCSel[1:0]               next PC: 0=PC+4, 1=ALU
//   RegWEn, ASel, BSel       register write, A=PC, B=imm
//   WBSel[1:0]               write-back: 0=mem, 1=ALU, 2=PC+4
//   ImmSel[2:0]              immediate format
//   ALUSel[3:0]              ALU operation
//   load_op[2:0], store_op   load funct3 / store funct3[1:0]
//   illegal, timeout         sticky error flags
//   busy                     low only while idling in FETCH right after reset
module multicycle_controller #(
  parameter int unsigned TO_W            = 4,
  parameter int unsigned TRAP_ON_ILLEGAL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ack,
  input  logic        br_eq,
  input  logic        br_lt,
  input  logic        br_ltu,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  PCSel,
  output logic        RegWEn,
  output logic        ASel,
  output logic        BSel,
  output logic [1:0]  WBSel,
  output logic [2:0]  ImmSel,
  output logic [3:0]  ALUSel,
  output logic [2:0]  load_op,
  output logic [1:0]  store_op,
  output logic        illegal,
  output logic        timeout,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_e;

  state_e            state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              run_q;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] f3;
  logic       f7b5;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign f3           = instr[14:12];
  assign f7b5         = instr[30];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  // Decode results
  logic       is_load, is_store, is_opimm, is_op, is_lui, is_auipc;
  logic       is_branch, is_jal, is_jalr, dec_legal, br_taken;
  logic [3:0] d_alu;
  logic [2:0] d_imm;
  logic       d_asel, d_bsel;
  logic [1:0] d_wbsel;

  always_comb begin
    is_load   = (opcode == 7'h03);
    is_store  = (opcode == 7'h23);
    is_opimm  = (opcode == 7'h13);
    is_op     = (opcode == 7'h33);
    is_lui    = (opcode == 7'h37);
    is_auipc  = (opcode == 7'h17);
    is_branch = (opcode == 7'h63);
    is_jal    = (opcode == 7'h6F);
    is_jalr   = (opcode == 7'h67);

    dec_legal = (is_load | is_store | is_opimm | is_op | is_lui | is_auipc |
                 is_branch | is_jal | is_jalr) &&
                !(is_load && (f3 == 3'd7)) &&
                !(is_store && (f3 > 3'd2)) &&
                !(is_branch && ((f3 == 3'd2) || (f3 == 3'd3)));

    br_taken = 1'b0;
    case (f3)
      3'd0:    br_taken = br_eq;
      3'd1:    br_taken = !br_eq;
      3'd4:    br_taken = br_lt;
      3'd5:    br_taken = !br_lt;
      3'd6:    br_taken = br_ltu;
      3'd7:    br_taken = !br_ltu;
      default: br_taken = 1'b0;
    endcase

    d_alu   = 4'd0;
    d_imm   = 3'd0;
    d_asel  = 1'b0;
    d_bsel  = 1'b0;
    d_wbsel = 2'd1;
    if (is_op || is_opimm) begin
      case (f3)
        3'd0:    d_alu = (is_op && f7b5) ? 4'd1 : 4'd0;
        3'd1:    d_alu = 4'd2;
        3'd2:    d_alu = 4'd3;
        3'd3:    d_alu = 4'd4;
        3'd4:    d_alu = 4'd5;
        3'd5:    d_alu = f7b5 ? 4'd7 : 4'd6;
        3'd6:    d_alu = 4'd8;
        default: d_alu = 4'd9;
      endcase
      d_bsel = is_opimm;
      d_imm  = (is_opimm && ((f3 == 3'd1) || (f3 == 3'd5))) ? 3'd1 : 3'd0;
    end else if (is_load) begin
      d_bsel  = 1'b1;
      d_wbsel = 2'd0;
    end else if (is_store) begin
      d_bsel = 1'b1;
      d_imm  = 3'd2;
    end else if (is_lui) begin
      d_alu  = 4'd10;
      d_bsel = 1'b1;
      d_imm  = 3'd3;
    end else if (is_auipc || is_branch) begin
      d_asel = 1'b1;
      d_bsel = 1'b1;
      d_imm  = 3'd3;
    end else if (is_jal) begin
      d_asel  = 1'b1;
      d_bsel  = 1'b1;
      d_imm   = 3'd5;
      d_wbsel = 2'd2;
    end else if (is_jalr) begin
      d_bsel  = 1'b1;
      d_wbsel = 2'd2;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    PCSel     = 2'd0;
    RegWEn    = 1'b0;
    ASel      = 1'b0;
    BSel      = 1'b0;
    WBSel     = 2'd0;
    ImmSel    = 3'd0;
    ALUSel    = 4'd0;
    load_op   = 3'd0;
    store_op  = 2'd0;
    busy      = !((state_q == S_FETCH) && !run_q);

    // Selects are only steered while an instruction is in flight
    if ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) begin
      ASel     = d_asel;
      BSel     = d_bsel;
      WBSel    = d_wbsel;
      ImmSel   = d_imm;
      ALUSel   = d_alu;
      load_op  = is_load ? f3 : 3'd0;
      store_op = is_store ? f3[1:0] : 2'd0;
    end

    case (state_q)
      S_FETCH: begin
        // run_q holds off the first request until the edge after reset release
        if (run_q) begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_we   = 1'b1;
            state_d = S_DECODE;
          end else if (cnt_q == '1) begin
            timeout_d = 1'b1;
            state_d   = S_TRAP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          state_d = S_EXEC;
        end else if (TRAP_ON_ILLEGAL != 0) begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          pc_we   = 1'b1;
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end
      S_EXEC: begin
        if (is_load || is_store) begin
          state_d = S_MEM;
          cnt_d   = '0;
        end else if (is_branch) begin
          pc_we   = 1'b1;
          PCSel   = {1'b0, br_taken};
          state_d = S_FETCH;
          cnt_d   = '0;
        end else if (is_jal || is_jalr) begin
          RegWEn  = 1'b1;
          pc_we   = 1'b1;
          PCSel   = 2'd1;
          state_d = S_FETCH;
          cnt_d   = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        if (mem_ack) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
            cnt_d   = '0;
          end
        end else if (cnt_q == '1) begin
          timeout_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        RegWEn  = 1'b1;
        pc_we   = 1'b1;
        state_d = S_FETCH;
        cnt_d   = '0;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      run_q     <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      run_q     <= 1'b1;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign illegal = illegal_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
//   Self-checking bench for multicycle_controller. Two instances share the
//   stimulus: one traps on illegal opcodes, the other skips them. Expected
//   behaviour per instruction (selects, strobe counts, latency) comes from a
//   directed table and from an instruction-level reference model.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        mem_ack = 1'b0, br_eq = 1'b0, br_lt = 1'b0, br_ltu = 1'b0;

  logic mem_req, mem_we, ir_we, pc_we, RegWEn, ASel, BSel, illegal, timeout, busy;
  logic [1:0] PCSel, WBSel, store_op;
  logic [2:0] ImmSel, load_op;
  logic [3:0] ALUSel;

  logic mem_req_n, mem_we_n, ir_we_n, pc_we_n, RegWEn_n, ASel_n, BSel_n, illegal_n, timeout_n, busy_n;
  logic [1:0] PCSel_n, WBSel_n, store_op_n;
  logic [2:0] ImmSel_n, load_op_n;
  logic [3:0] ALUSel_n;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.TO_W(4), .TRAP_ON_ILLEGAL(1)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ack(mem_ack),
    .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu),
    .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we),
    .PCSel(PCSel), .RegWEn(RegWEn), .ASel(ASel), .BSel(BSel), .WBSel(WBSel),
    .ImmSel(ImmSel), .ALUSel(ALUSel), .load_op(load_op), .store_op(store_op),
    .illegal(illegal), .timeout(timeout), .busy(busy)
  );

  multicycle_controller #(.TO_W(4), .TRAP_ON_ILLEGAL(0)) dut_nt (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ack(mem_ack),
    .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu),
    .mem_req(mem_req_n), .mem_we(mem_we_n), .ir_we(ir_we_n), .pc_we(pc_we_n),
    .PCSel(PCSel_n), .RegWEn(RegWEn_n), .ASel(ASel_n), .BSel(BSel_n), .WBSel(WBSel_n),
    .ImmSel(ImmSel_n), .ALUSel(ALUSel_n), .load_op(load_op_n), .store_op(store_op_n),
    .illegal(illegal_n), .timeout(timeout_n), .busy(busy_n)
  );

  // Expected per-instruction behaviour
  typedef struct {
    int alu; int imm; int asel; int bsel; int wbsel; int regw;
    int memph; int mem_we; int pcsel; int lat; int lop; int sop;
  } exp_t;

  typedef struct {
    logic [31:0] ins; bit eq; bit lt; bit ltu; int fw; int mw; exp_t e;
  } vec_t;

  int alu_map[8] = '{0, 2, 3, 4, 5, 6, 8, 9};

  task automatic chk(input string tag, input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s.%s actual=%0d expected=%0d", tag, nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ins, input bit eq, input bit lt, input bit ltu);
    exp_t e;
    int f3;
    bit alt;
    e = '{default: 0};
    f3 = int'(ins[14:12]);
    alt = ins[30];
    e.memph = 1; e.lat = 4; e.wbsel = 1;
    e.alu = alu_map[f3];
    if (f3 == 5 && alt) e.alu = 7;
    case (ins[6:0])
      7'h03: begin e.alu = 0; e.bsel = 1; e.wbsel = 0; e.regw = 1; e.memph = 2; e.lat = 5; e.lop = f3; end
      7'h23: begin e.alu = 0; e.bsel = 1; e.imm = 2; e.wbsel = 0; e.memph = 2; e.mem_we = 1; e.sop = f3 % 4; end
      7'h13: begin e.bsel = 1; e.imm = (f3 == 1 || f3 == 5) ? 1 : 0; e.regw = 1; end
      7'h33: begin if (f3 == 0 && alt) e.alu = 1; e.regw = 1; end
      7'h37: begin e.alu = 10; e.imm = 3; e.bsel = 1; e.regw = 1; end
      7'h17: begin e.alu = 0; e.imm = 3; e.asel = 1; e.bsel = 1; e.regw = 1; end
      7'h63: begin
        e.alu = 0; e.imm = 3; e.asel = 1; e.bsel = 1; e.lat = 3; e.wbsel = 0;
        case (f3)
          0: e.pcsel = int'(eq);
          1: e.pcsel = int'(!eq);
          4: e.pcsel = int'(lt);
          5: e.pcsel = int'(!lt);
          6: e.pcsel = int'(ltu);
          default: e.pcsel = int'(!ltu);
        endcase
      end
      7'h6F: begin e.alu = 0; e.imm = 5; e.asel = 1; e.bsel = 1; e.regw = 1; e.wbsel = 2; e.pcsel = 1; e.lat = 3; end
      default: begin e.alu = 0; e.imm = 0; e.bsel = 1; e.regw = 1; e.wbsel = 2; e.pcsel = 1; e.lat = 3; end
    endcase
    return e;
  endfunction

  // Reset, check the quiet state, release, and leave the DUT one cycle into
  // FETCH (called and returning at posedge+1).
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    mem_ack = 1'b0;
    #3;
    chk(tag, "rst_mem_req", int'(mem_req), 0);
    chk(tag, "rst_outs", int'({PCSel, RegWEn, ASel, BSel, WBSel, ImmSel, ALUSel,
                               load_op, store_op, mem_we, ir_we, pc_we}), 0);
    chk(tag, "rst_flags", int'({illegal, timeout, illegal_n, timeout_n}), 0);
    chk(tag, "rst_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk(tag, "rel_mem_req", int'(mem_req), 0);
    @(posedge clk);
    #1;
    chk(tag, "first_fetch", int'(mem_req), 1);
    chk(tag, "first_busy", int'(busy), 1);
  endtask

  // Runs one instruction from FETCH back to FETCH, acking the fetch after fw
  // request cycles and the data access after mw request cycles.
  task automatic run_instr(input string tag, input logic [31:0] ins, input bit eq,
                           input bit lt, input bit ltu, input int fw, input int mw,
                           input exp_t e);
    int cyc, waits, phase, reqc, irc, pcc, rwc, ir_cyc, wb_rw, pcs, sawwe, done;
    int ex_alu, ex_imm, ex_asel, ex_bsel, ex_lop, ex_sop;
    cyc = 0; waits = 0; phase = 0; reqc = 0; irc = 0; pcc = 0; rwc = 0;
    ir_cyc = 0; wb_rw = -1; pcs = -1; sawwe = 0; done = 0;
    ex_alu = -1; ex_imm = -1; ex_asel = -1; ex_bsel = -1; ex_lop = -1; ex_sop = -1;
    instr = ins; br_eq = eq; br_lt = lt; br_ltu = ltu;
    for (int c = 0; c < 200 && done == 0; c++) begin
      mem_ack = 1'b0;
      if (mem_req && reqc == ((phase == 0) ? fw : mw)) mem_ack = 1'b1;
      @(negedge clk);
      cyc++;
      if (mem_req && !mem_ack) waits++;
      if (mem_req) reqc++;
      if (mem_req && mem_ack) begin phase++; reqc = 0; end
      if (mem_req && mem_we) sawwe = 1;
      if (ir_we) begin irc++; ir_cyc = cyc; end
      if (ir_cyc != 0 && cyc == ir_cyc + 2) begin
        ex_alu = int'(ALUSel); ex_imm = int'(ImmSel); ex_asel = int'(ASel);
        ex_bsel = int'(BSel); ex_lop = int'(load_op); ex_sop = int'(store_op);
      end
      if (RegWEn) begin rwc++; wb_rw = int'(WBSel); end
      if (pc_we) begin pcc++; pcs = int'(PCSel); done = 1; end
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b0;
    chk(tag, "completed", done, 1);
    chk(tag, "latency", cyc - waits, e.lat);
    chk(tag, "ir_we_cnt", irc, 1);
    chk(tag, "pc_we_cnt", pcc, 1);
    chk(tag, "regwen_cnt", rwc, e.regw);
    chk(tag, "mem_phases", phase, e.memph);
    chk(tag, "mem_we", sawwe, e.mem_we);
    chk(tag, "pcsel", pcs, e.pcsel);
    if (e.regw != 0) chk(tag, "wbsel", wb_rw, e.wbsel);
    chk(tag, "alusel", ex_alu, e.alu);
    chk(tag, "immsel", ex_imm, e.imm);
    chk(tag, "asel", ex_asel, e.asel);
    chk(tag, "bsel", ex_bsel, e.bsel);
    chk(tag, "load_op", ex_lop, e.lop);
    chk(tag, "store_op", ex_sop, e.sop);
    chk(tag, "back_to_fetch", int'(mem_req), 1);
    chk(tag, "flags", int'({illegal, timeout}), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[18];
    logic [6:0] ops[9];
    logic [31:0] ill[4];
    logic [31:0] ri;
    bit req, rlt, rltu;
    int n, pc1, pcn, rw, found;

    tbl = '{
      '{32'h002081B3, 0, 0, 0,  2,  0, '{0, 0, 0, 0, 1, 1, 1, 0, 0, 4, 0, 0}},  // add
      '{32'h0000A183, 0, 0, 0,  1,  2, '{0, 0, 0, 1, 0, 1, 2, 0, 0, 5, 2, 0}},  // lw
      '{32'h00209463, 0, 0, 0,  0,  0, '{0, 3, 1, 1, 0, 0, 1, 0, 1, 3, 0, 0}},  // bne taken
      '{32'h00209463, 1, 0, 0,  1,  0, '{0, 3, 1, 1, 0, 0, 1, 0, 0, 3, 0, 0}},  // bne not taken
      '{32'h0020A023, 0, 0, 0,  0,  3, '{0, 2, 0, 1, 0, 0, 2, 1, 0, 4, 0, 2}},  // sw
      '{32'h402081B3, 0, 0, 0,  0,  0, '{1, 0, 0, 0, 1, 1, 1, 0, 0, 4, 0, 0}},  // sub
      '{32'h4030D193, 0, 0, 0,  0,  0, '{7, 1, 0, 1, 1, 1, 1, 0, 0, 4, 0, 0}},  // srai
      '{32'h123452B7, 0, 0, 0,  0,  0, '{10, 3, 0, 1, 1, 1, 1, 0, 0, 4, 0, 0}}, // lui
      '{32'h00001297, 0, 0, 0,  0,  0, '{0, 3, 1, 1, 1, 1, 1, 0, 0, 4, 0, 0}},  // auipc
      '{32'h010000EF, 0, 0, 0,  0,  0, '{0, 5, 1, 1, 2, 1, 1, 0, 1, 3, 0, 0}},  // jal
      '{32'h00008067, 0, 0, 0,  0,  0, '{0, 0, 0, 1, 2, 1, 1, 0, 1, 3, 0, 0}},  // jalr
      '{32'h0020C463, 0, 1, 0,  0,  0, '{0, 3, 1, 1, 0, 0, 1, 0, 1, 3, 0, 0}},  // blt taken
      '{32'h0020F463, 0, 0, 1,  0,  0, '{0, 3, 1, 1, 0, 0, 1, 0, 0, 3, 0, 0}},  // bgeu not taken
      '{32'h002081B3, 0, 0, 0, 15,  0, '{0, 0, 0, 0, 1, 1, 1, 0, 0, 4, 0, 0}},  // ack at saturation
      '{32'h0000A183, 0, 0, 0,  0, 15, '{0, 0, 0, 1, 0, 1, 2, 0, 0, 5, 2, 0}},  // mem ack at saturation
      '{32'h0040C193, 0, 0, 0,  0,  0, '{5, 0, 0, 1, 1, 1, 1, 0, 0, 4, 0, 0}},  // xori
      '{32'h0020B1B3, 0, 0, 0,  0,  0, '{4, 0, 0, 0, 1, 1, 1, 0, 0, 4, 0, 0}},  // sltu
      '{32'h00309193, 0, 0, 0,  0,  0, '{2, 1, 0, 1, 1, 1, 1, 0, 0, 4, 0, 0}}   // slli
    };
    ops = '{7'h03, 7'h13, 7'h23, 7'h33, 7'h37, 7'h17, 7'h63, 7'h6F, 7'h67};
    ill = '{32'h0000007F, 32'h0000F183, 32'h0020B023, 32'h0020A463};

    do_reset("reset0");

    for (int i = 0; i < 18; i++)
      run_instr($sformatf("vec%0d", i), tbl[i].ins, tbl[i].eq, tbl[i].lt, tbl[i].ltu,
                tbl[i].fw, tbl[i].mw, tbl[i].e);

    for (int i = 0; i < 40; i++) begin
      ri = $urandom;
      ri[6:0] = ops[$urandom_range(0, 8)];
      if (ri[6:0] == 7'h03 && ri[14:12] == 3'd7) ri[14:12] = 3'd2;
      if (ri[6:0] == 7'h23) ri[14:12] = 3'($urandom_range(0, 2));
      if (ri[6:0] == 7'h63) ri[13] = 1'b0;
      req = 1'($urandom_range(0, 1));
      rlt = 1'($urandom_range(0, 1));
      rltu = 1'($urandom_range(0, 1));
      run_instr($sformatf("rnd%0d_%08h", i, ri), ri, req, rlt, rltu,
                $urandom_range(0, 6), $urandom_range(0, 6), model(ri, req, rlt, rltu));
    end

    // Fetch timeout: no ack at all
    do_reset("tmo");
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!mem_req) break;
      n++;
    end
    chk("tmo", "req_cycles", n, 16);
    chk("tmo", "timeout", int'(timeout), 1);
    chk("tmo", "mem_req", int'(mem_req), 0);
    chk("tmo", "busy", int'(busy), 1);
    @(posedge clk); #1;
    mem_ack = 1'b1;
    rw = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      rw += int'(ir_we) + int'(pc_we) + int'(RegWEn) + int'(mem_req);
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    chk("tmo", "trap_quiet", rw, 0);
    chk("tmo", "still_timeout", int'(timeout), 1);

    // Illegal encodings: trap instance vs skip instance
    for (int k = 0; k < 4; k++) begin
      do_reset($sformatf("ill%0d", k));
      instr = ill[k];
      pc1 = 0; pcn = 0; rw = 0;
      mem_ack = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        pc1 += int'(pc_we);
        pcn += int'(pc_we_n);
        rw += int'(RegWEn) + int'(RegWEn_n);
        @(posedge clk); #1;
        mem_ack = 1'b0;
      end
      chk($sformatf("ill%0d", k), "illegal", int'(illegal), 1);
      chk($sformatf("ill%0d", k), "illegal_nt", int'(illegal_n), 0);
      chk($sformatf("ill%0d", k), "pc_we_trap", pc1, 0);
      chk($sformatf("ill%0d", k), "pc_we_nt", pcn, 1);
      chk($sformatf("ill%0d", k), "regwen", rw, 0);
      chk($sformatf("ill%0d", k), "mem_req_trap", int'(mem_req), 0);
      chk($sformatf("ill%0d", k), "mem_req_nt", int'(mem_req_n), 1);
    end

    // Reset asserted while a store waits in MEM
    do_reset("rstmem");
    instr = 32'h0020A023;
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      if (mem_req && mem_we) found = 1;
      else begin @(posedge clk); #1; end
    end
    chk("rstmem", "reached_mem", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmem", "mem_req_async", int'(mem_req), 0);
    chk("rstmem", "strobes", int'({pc_we, RegWEn, mem_we}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstmem", "rel_pc_we", int'(pc_we), 0);
    @(posedge clk); #1;
    chk("rstmem", "refetch", int'({mem_req, mem_we}), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
